// File: rtl/aes_pkg.sv
// aes_pkg: shell states, widths and AES-128 round primitives on the byte-0-at-LSB map
package aes_pkg;
  typedef enum logic [1:0] {LOAD_KEY, LOAD_DATA, CALC, SEND} state_t;
  typedef logic [10:0][127:0] rk_t;
  localparam int BLOCK_W = 128;
  localparam int CNT_W = 7;
  localparam int LAST_BIT = 127;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xt(x);
    end
    return p;
  endfunction
  // multiplicative inverse as a^254, which also maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 8; i++) r = (i == 7) ? gmul(r, r) : gmul(gmul(r, r), a);
    return r;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction
  function automatic logic [7:0] cb(input logic [127:0] s, input int c, input int r);
    return s[8*((r % 4) + 4*c) +: 8];
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv ? isbox(s[8*i +: 8]) : sbox(s[8*i +: 8]);
    return o;
  endfunction
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[8*(r + 4*c) +: 8] = cb(s, (inv ? c + 4 - r : c + r) % 4, r);
    return o;
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r + 4*c) +: 8] = inv ?
          gmul(cb(s, c, r), 8'h0e) ^ gmul(cb(s, c, r + 1), 8'h0b) ^ gmul(cb(s, c, r + 2), 8'h0d) ^ gmul(cb(s, c, r + 3), 8'h09) :
          xt(cb(s, c, r)) ^ xt(cb(s, c, r + 1)) ^ cb(s, c, r + 1) ^ cb(s, c, r + 2) ^ cb(s, c, r + 3);
    return o;
  endfunction
  function automatic rk_t key_exp(input logic [127:0] key);
    rk_t rk;
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    rk[0] = key;
    for (int r = 1; r <= 10; r++) begin
      t = rk[r-1][127:96];
      t = {t[7:0], t[31:8]};
      t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {24'h000000, rc};
      rk[r][31:0] = rk[r-1][31:0] ^ t;
      for (int k = 1; k < 4; k++) rk[r][32*k +: 32] = rk[r-1][32*k +: 32] ^ rk[r][32*(k-1) +: 32];
      rc = xt(rc);
    end
    return rk;
  endfunction
  function automatic logic [127:0] aes_enc(input logic [127:0] d, input logic [127:0] key);
    rk_t rk;
    logic [127:0] s;
    rk = key_exp(key);
    s = d ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (r < 10) s = mix_columns(s, 1'b0);
      s = s ^ rk[r];
    end
    return s;
  endfunction
  function automatic logic [127:0] aes_dec(input logic [127:0] d, input logic [127:0] key);
    rk_t rk;
    logic [127:0] s;
    rk = key_exp(key);
    s = d ^ rk[10];
    for (int r = 9; r >= 0; r--) begin
      s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[r];
      if (r > 0) s = mix_columns(s, 1'b1);
    end
    return s;
  endfunction
endpackage

// File: rtl/aes_bit_reg128.sv
// aes_bit_reg128: 128-bit register with indexed single-bit write and full parallel load
module aes_bit_reg128
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [CNT_W-1:0]   idx,
  input  logic               d,
  input  logic               ld,
  input  logic [BLOCK_W-1:0] ld_d,
  output logic [BLOCK_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (ld) q <= ld_d;
    else if (we) q[idx] <= d;
  end
endmodule

// File: rtl/aes_decrypt.sv
// aes_decrypt: combinational AES-128 decryption of one block
module aes_decrypt
  import aes_pkg::*;
(
  input  logic [127:0] data,
  input  logic [127:0] key,
  output logic [127:0] res
);
  assign res = aes_dec(data, key);
endmodule

// File: rtl/aes_encrypt.sv
// aes_encrypt: combinational AES-128 encryption of one block
module aes_encrypt
  import aes_pkg::*;
(
  input  logic [127:0] data,
  input  logic [127:0] key,
  output logic [127:0] res
);
  assign res = aes_enc(data, key);
endmodule

// File: rtl/aes_serial_shell.sv
// aes_serial_shell: bit-serial load/compute/unload wrapper around the AES-128 cores
module aes_serial_shell #(
  parameter int BLOCK_W = 128,
  parameter int CNT_W = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic mode,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  output logic out_bit,
  input  logic out_ready
);
  import aes_pkg::*;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic mode_r, in_xfer, out_xfer, last, key_we, data_we, res_ld;
  logic [BLOCK_W-1:0] key_r, data_r, res_r, enc_res, dec_res;
  always_comb begin
    in_ready = !rst && (state == LOAD_KEY || state == LOAD_DATA);
    out_valid = state == SEND;
    out_bit = out_valid && res_r[cnt];
    in_xfer = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
    last = cnt == CNT_W'(LAST_BIT);
    key_we = in_xfer && state == LOAD_KEY;
    data_we = in_xfer && state == LOAD_DATA;
    res_ld = state == CALC;
    state_nx = state == CALC ? SEND :
               !((in_xfer || out_xfer) && last) ? state :
               state == LOAD_KEY ? LOAD_DATA :
               state == LOAD_DATA ? CALC : LOAD_KEY;
  end
  // the counter wraps 127 -> 0 on its own, so every phase ends with cnt back at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_KEY;
      cnt <= '0;
      mode_r <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= (in_xfer || out_xfer) ? cnt + CNT_W'(1) : cnt;
      mode_r <= (data_we && last) ? mode : mode_r;
    end
  end
  aes_bit_reg128 u_key (.clk(clk), .rst(rst), .we(key_we), .idx(cnt), .d(in_bit),
                        .ld(1'b0), .ld_d('0), .q(key_r));
  aes_bit_reg128 u_data (.clk(clk), .rst(rst), .we(data_we), .idx(cnt), .d(in_bit),
                         .ld(1'b0), .ld_d('0), .q(data_r));
  aes_bit_reg128 u_res (.clk(clk), .rst(rst), .we(1'b0), .idx(cnt), .d(1'b0),
                        .ld(res_ld), .ld_d(mode_r ? enc_res : dec_res), .q(res_r));
  aes_encrypt u_enc (.data(data_r), .key(key_r), .res(enc_res));
  aes_decrypt u_dec (.data(data_r), .key(key_r), .res(dec_res));
endmodule

// File: tb/tb_aes_serial_shell.sv
// tb_aes_serial_shell: known-answer, inverse-roundtrip, throttling and reset checks on the serial shell
module tb_aes_serial_shell;
  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_bit;
  int n_chk = 0, n_pass = 0;
  localparam logic [127:0] ZERO_CT = 128'h2e2b34ca59fa4c883b2c8aefd44be966;
  localparam logic [127:0] FK = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] FP = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] FC = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  always #5 clk = ~clk;
  aes_serial_shell dut (.clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_bit(in_bit),
                        .in_ready(in_ready), .out_valid(out_valid), .out_bit(out_bit), .out_ready(out_ready));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) begin
      tick();
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_out_bit", 128'(out_bit), 128'd0);
    end
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 128'(in_ready), 128'd1);
    chk("rel_out_valid", 128'(out_valid), 128'd0);
  endtask
  // abort_at: serial position (0..255 load, 256+j send) at which rst is pulsed; -1 for none
  task automatic run_frame(input logic [127:0] k, input logic [127:0] d, input logic m,
                           input bit thr, input int abort_at, output logic [127:0] r);
    int i = 0, j = 0, guard = 0;
    logic xfer, stalled = 1'b0, prev = 1'b0;
    r = '0;
    while (i < 256 && i != abort_at && guard < 5000) begin
      in_valid = thr ? 1'($urandom) : 1'b1;
      in_bit = i < 128 ? k[i] : d[i-128];
      mode = i == 255 ? m : ~m;
      xfer = in_valid && in_ready;
      tick();
      guard++;
      if (xfer) i++;
    end
    if (i == abort_at) begin
      do_reset(1);
      return;
    end
    chk("load_done", 128'(i), 128'd256);
    in_valid = 1'b1;
    in_bit = 1'($urandom);
    chk("calc_out_valid", 128'(out_valid), 128'd0);
    chk("calc_in_ready", 128'(in_ready), 128'd0);
    tick();
    chk("first_out_valid", 128'(out_valid), 128'd1);
    while (j < 128 && 256 + j != abort_at && guard < 10000) begin
      out_ready = thr ? 1'($urandom) : 1'b1;
      in_valid = 1'($urandom);
      in_bit = 1'($urandom);
      chk("send_in_ready", 128'(in_ready), 128'd0);
      chk("send_out_valid", 128'(out_valid), 128'd1);
      if (stalled) chk("stall_hold", 128'(out_bit), 128'(prev));
      stalled = out_valid && !out_ready;
      prev = out_bit;
      xfer = out_valid && out_ready;
      if (xfer) r[j] = out_bit;
      tick();
      guard++;
      if (xfer) j++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    if (256 + j == abort_at) begin
      do_reset(1);
      repeat (5) begin
        tick();
        chk("no_residual", 128'(out_valid), 128'd0);
      end
      return;
    end
    chk("send_done", 128'(j), 128'd128);
    chk("post_in_ready", 128'(in_ready), 128'd1);
    chk("post_out_valid", 128'(out_valid), 128'd0);
  endtask
  initial begin
    logic [127:0] r, c, k, d;
    do_reset(3);
    run_frame('0, '0, 1'b1, 1'b0, -1, r);
    chk("zero_enc", r, ZERO_CT);
    run_frame(FK, FP, 1'b1, 1'b0, -1, r);
    chk("fips_enc", r, FC);
    run_frame(FK, FC, 1'b0, 1'b0, -1, r);
    chk("fips_dec", r, FP);
    run_frame(FK, FP, 1'b1, 1'b1, -1, r);
    chk("thr_enc", r, FC);
    run_frame(FK, FC, 1'b0, 1'b1, -1, r);
    chk("thr_dec", r, FP);
    run_frame(FK, FP, 1'b1, 1'b0, 60, r);
    run_frame(FK, FP, 1'b1, 1'b0, -1, r);
    chk("after_key_rst", r, FC);
    run_frame(FK, FP, 1'b1, 1'b1, 296, r);
    run_frame('0, '0, 1'b1, 1'b0, -1, r);
    chk("after_send_rst", r, ZERO_CT);
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      run_frame(k, d, 1'b1, n[0], -1, c);
      run_frame(k, c, 1'b0, 1'b1, -1, r);
      chk("roundtrip", r, d);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aes_serial_shell.md
# aes_serial_shell

Bit-serial front end for the combinational AES-128 cores. It receives a 128-bit key and a 128-bit data block one bit per transfer, runs `aes_encrypt` or `aes_decrypt` on them, and returns the 128-bit result one bit per transfer. It sits between the FPGA pins and the AES cores, and replaces the tie-off style top level with a real load/compute/unload protocol.

## Interface
Parameters:
- `BLOCK_W`, default 128: key, data and result width. Only 128 is supported.
- `CNT_W`, default 7: bit-counter width. Must equal clog2(`BLOCK_W`).

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mode` in 1: 1 = encrypt, 0 = decrypt. Sampled only on the cycle the last data bit is accepted.
- `in_valid` in 1: `in_bit` is valid this cycle.
- `in_bit` in 1: serial key/data bit.
- `in_ready` out 1: shell accepts a bit this cycle.
- `out_valid` out 1: `out_bit` is valid.
- `out_bit` out 1: serial result bit.
- `out_ready` in 1: sink accepts `out_bit` this cycle.

## Operation
Bit order:
- All vectors use the codebase byte map: byte 0 = bits 7:0 (row 0, col 0), byte 15 = bits 127:120.
- Serial order is bit 0 first, bit 127 last.

State machine:
- States: `LOAD_KEY`, `LOAD_DATA`, `CALC`, `SEND`.
- A 7-bit counter `cnt` tracks the bit index.
- An input transfer occurs when `in_valid && in_ready`.
- An output transfer occurs when `out_valid && out_ready`.

State behaviour:
- `LOAD_KEY`: `in_ready`=1. Each transfer writes `key_r[cnt]`=`in_bit` and increments `cnt`. On transfer with `cnt`=127: `cnt`←0, go to `LOAD_DATA`.
- `LOAD_DATA`: `in_ready`=1. Each transfer writes `data_r[cnt]`. On transfer with `cnt`=127: latch `mode_r`←`mode`, `cnt`←0, go to `CALC`.
- `CALC`: `in_ready`=0, `out_valid`=0. Exactly one cycle. `res_r` ← `mode_r` ? `aes_encrypt(data_r,key_r)` : `aes_decrypt(data_r,key_r)`. Go to `SEND`.
- `SEND`: `out_valid`=1, `out_bit`=`res_r[cnt]`. Each transfer increments `cnt`. On transfer with `cnt`=127: `cnt`←0, go to `LOAD_KEY`.

Boundary conditions:
- `in_valid` is ignored outside the LOAD states. Bits offered in `CALC`/`SEND` are not consumed.
- Gaps in `in_valid` are allowed. The counter holds and the stored bits are kept.
- If `out_ready` is low in `SEND`, `out_bit` and `cnt` hold.
- The key is reloaded for every block. There is no key-persist mode.
- `rst` asserted in any state (mid-load, `CALC`, mid-send) aborts the operation. The next state is `LOAD_KEY` with `cnt`=0. The partial result is discarded and never emitted.

## Timing
Reset values:
- state=`LOAD_KEY`, `cnt`=0, `key_r`=`data_r`=`res_r`=0, `mode_r`=0.
- `out_valid`=0, `out_bit`=0.
- `in_ready`=0 while `rst` is high, and 1 from the first cycle after `rst` falls.

Cycle timing:
- Last data bit accepted at cycle t → `CALC` at t+1 → `out_valid`=1 with result bit 0 at t+2.
- Minimum frame is 256 + 1 + 128 = 385 cycles.
- After the final output transfer at cycle u, `in_ready`=1 at u+1.

Output timing:
- `out_valid` and `out_bit` come from registers or state decode only. There is no combinational path from `in_*` or `out_ready`.
- The AES core path is combinational but is registered into `res_r` in `CALC`. It is the single-cycle critical path, so the clock target must accommodate it.

## Structure
- Package `aes_pkg`:
  - state enum `{LOAD_KEY, LOAD_DATA, CALC, SEND}`
  - `BLOCK_W`=128, `CNT_W`=7, `LAST_BIT`=127
- Instantiate the existing `aes_encrypt` and `aes_decrypt`, fed from `key_r` and `data_r`.
- Sub-module `aes_bit_reg128` is natural:
  - 128-bit register with indexed single-bit write (`we`, `idx`, `d`) and indexed read (`q_bit`).
  - Used for key, data and result storage.

## Test plan
- Zero-vector encrypt: key=0, data=0, `mode`=1 → serial output equals 128'h2e2b34ca59fa4c883b2c8aefd44be966 (byte0=0x66), bit 0 first. `out_valid` rises exactly 2 cycles after the last data bit.
- FIPS-197 C.1:
  - key bytes 00..0f, data bytes 00 11 .. ff, `mode`=1 → output bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
  - Same key with those bytes as data and `mode`=0 → the plaintext bytes.
- Throttling: random `in_valid` gaps (~50% duty) and random `out_ready` stalls → identical result to the gap-free run. `out_bit` is stable across every stall. No bit is consumed or emitted twice.
- Mode sampling: `mode` toggles during load and is 0 only on the last data bit → decrypt result.
- Reset mid-operation:
  - `rst` pulsed at key bit 60, then a full clean frame → correct result.
  - `rst` pulsed at `SEND` bit 40 → `out_valid`=0 the next cycle, `in_ready`=1 after release. No residual bits are emitted.
- Back-to-back frames: a second frame starts immediately after the 128th output transfer → both results are correct. `in_ready` is 0 throughout `CALC`/`SEND`.
